// File: rtl/xbus_arbiter.sv
// xbus_arbiter: two-master round-robin arbiter for the picoversat data bus.
//   Master 0 (CPU) and master 1 (DMA) each present req/lock/addr/we/wdata.
//   The owning master's access is forwarded to the address decoder
//   (bus_sel/bus_addr/bus_we/bus_wdata). Read data from the decoder is
//   registered into mx_rdata, and a one-cycle mx_ack follows each access.
//   A locked owner keeps the bus for back-to-back accesses. When the other
//   master is waiting, the lock is broken after MAX_HOLD accesses.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   mX_req/lock/addr/we/wdata  master request side (X = 0, 1)
//   mX_gnt/ack/rdata     master response side
//   bus_sel/addr/we/wdata, bus_rdata   decoder side
module xbus_arbiter #(
  parameter int ADDR_W   = 13,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m0_we,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              m1_we,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              bus_sel,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_we,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata
);

  localparam int HC_W = $clog2(MAX_HOLD) + 1;

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t            state_q, state_d;
  logic              last_srv_q, last_srv_d;
  logic [HC_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic              ack0_q, ack0_d, ack1_q, ack1_d;
  logic [DATA_W-1:0] rd0_q, rd0_d, rd1_q, rd1_d;

  // Owner-relative view of the two masters.
  logic              busy, cur_m;
  logic              own_req, own_lock, own_we, oth_req;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_wdata;
  logic              forced;

  always_comb begin
    busy      = (state_q == OWN0) || (state_q == OWN1);
    cur_m     = (state_q == OWN1);
    own_req   = cur_m ? m1_req   : m0_req;
    own_lock  = cur_m ? m1_lock  : m0_lock;
    own_we    = cur_m ? m1_we    : m0_we;
    own_addr  = cur_m ? m1_addr  : m0_addr;
    own_wdata = cur_m ? m1_wdata : m0_wdata;
    oth_req   = cur_m ? m0_req   : m1_req;
    // Lock is broken on the MAX_HOLD-th locked access while the other waits.
    forced    = oth_req && (hold_cnt_q == HC_W'(MAX_HOLD - 1));
  end

  always_comb begin
    bus_sel   = busy && own_req;
    bus_we    = busy && own_req && own_we;
    bus_addr  = busy ? own_addr  : '0;
    bus_wdata = busy ? own_wdata : '0;
  end

  always_comb begin
    state_d    = state_q;
    last_srv_d = last_srv_q;
    hold_cnt_d = hold_cnt_q;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    rd0_d      = rd0_q;
    rd1_d      = rd1_q;
    unique case (state_q)
      IDLE: begin
        hold_cnt_d = '0;
        if (m0_req && m1_req) state_d = last_srv_q ? OWN0 : OWN1;
        else if (m0_req)      state_d = OWN0;
        else if (m1_req)      state_d = OWN1;
      end
      OWN0, OWN1: begin
        // Default: release, handing straight over if the other master waits.
        hold_cnt_d = '0;
        state_d    = oth_req ? (cur_m ? OWN0 : OWN1) : IDLE;
        if (own_req) begin
          last_srv_d = cur_m;
          if (cur_m) ack1_d = 1'b1;
          else       ack0_d = 1'b1;
          if (!own_we) begin
            if (cur_m) rd1_d = bus_rdata;
            else       rd0_d = bus_rdata;
          end
          if (own_lock && !forced) begin
            state_d    = state_q;
            hold_cnt_d = oth_req ? hold_cnt_q + 1'b1 : '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_srv_q <= 1'b1;
      hold_cnt_q <= '0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      rd0_q      <= '0;
      rd1_q      <= '0;
    end else begin
      state_q    <= state_d;
      last_srv_q <= last_srv_d;
      hold_cnt_q <= hold_cnt_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      rd0_q      <= rd0_d;
      rd1_q      <= rd1_d;
    end
  end

  assign m0_gnt   = (state_q == OWN0);
  assign m1_gnt   = (state_q == OWN1);
  assign m0_ack   = ack0_q;
  assign m1_ack   = ack1_q;
  assign m0_rdata = rd0_q;
  assign m1_rdata = rd1_q;

endmodule

// File: tb/tb_xbus_arbiter.sv
// Scoreboard bench for xbus_arbiter: stimulus pushes expected bus
// transactions and ack responses; a negedge monitor pops and compares.
module tb_xbus_arbiter;

  localparam int AW = 13;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          m0_req = 0, m0_lock = 0, m0_we = 0;
  logic [AW-1:0] m0_addr = '0;
  logic [DW-1:0] m0_wdata = '0;
  logic          m1_req = 0, m1_lock = 0, m1_we = 0;
  logic [AW-1:0] m1_addr = '0;
  logic [DW-1:0] m1_wdata = '0;
  logic          m0_gnt, m0_ack, m1_gnt, m1_ack;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          bus_sel, bus_we;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata, bus_rdata;

  xbus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_we(m0_we),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_we(m1_we),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .bus_sel(bus_sel), .bus_addr(bus_addr), .bus_we(bus_we),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  // Decoder/slave model: fixed pattern per address.
  function automatic logic [DW-1:0] slave(input logic [AW-1:0] a);
    return (a == 13'h010) ? 32'hDEADBEEF : {16'hC0DE, 3'b000, a};
  endfunction
  assign bus_rdata = bus_sel ? slave(bus_addr) : '0;

  typedef struct { bit m; logic [AW-1:0] addr; bit we; logic [DW-1:0] wd; } bus_t;
  typedef struct { bit m; logic [DW-1:0] rd; } ack_t;
  bus_t bus_q[$];
  ack_t ack_q[$];
  logic [DW-1:0] exp_rd [2];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input bit m, input bit req, input bit lock,
                       input logic [AW-1:0] a, input bit we, input logic [DW-1:0] wd);
    if (m) begin m1_req = req; m1_lock = lock; m1_addr = a; m1_we = we; m1_wdata = wd; end
    else   begin m0_req = req; m0_lock = lock; m0_addr = a; m0_we = we; m0_wdata = wd; end
  endtask

  task automatic push(input bit m, input logic [AW-1:0] a, input bit we, input logic [DW-1:0] wd);
    bus_q.push_back('{m: m, addr: a, we: we, wd: wd});
    if (!we) exp_rd[m] = slave(a);
    ack_q.push_back('{m: m, rd: exp_rd[m]});
  endtask

  task automatic check_idle(input string name);
    chk({name, "_gnt"},   {30'd0, m1_gnt, m0_gnt}, 32'd0);
    chk({name, "_ack"},   {30'd0, m1_ack, m0_ack}, 32'd0);
    chk({name, "_sel"},   {31'd0, bus_sel}, 32'd0);
    chk({name, "_rd0"},   m0_rdata, exp_rd[0]);
    chk({name, "_rd1"},   m1_rdata, exp_rd[1]);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    exp_rd[0] = '0; exp_rd[1] = '0;
    @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
  endtask

  // Single unlocked access from IDLE with gnt/ack timing checks.
  task automatic solo(input bit m, input logic [AW-1:0] a, input bit we, input logic [DW-1:0] wd);
    tick();
    drive(m, 1, 0, a, we, wd);
    push(m, a, we, wd);
    @(negedge clk);
    chk("solo_req_cycle_gnt", {31'd0, m ? m1_gnt : m0_gnt}, 32'd0);
    tick();
    @(negedge clk);
    chk("solo_gnt", {31'd0, m ? m1_gnt : m0_gnt}, 32'd1);
    chk("solo_sel", {31'd0, bus_sel}, 32'd1);
    tick();
    drive(m, 0, 0, a, 0, 0);
    @(negedge clk);
    chk("solo_ack", {31'd0, m ? m1_ack : m0_ack}, 32'd1);
    chk("solo_rdata", m ? m1_rdata : m0_rdata, exp_rd[m]);
    chk("solo_release", {30'd0, m1_gnt, m0_gnt}, 32'd0);
  endtask

  // Simultaneous request from IDLE; 'first' is the expected winner.
  task automatic tie(input bit first);
    bit sec;
    sec = ~first;
    tick();
    drive(0, 1, 0, 13'h040, 0, 0);
    drive(1, 1, 0, 13'h050, 0, 0);
    push(first, first ? 13'h050 : 13'h040, 0, 0);
    push(sec,   sec   ? 13'h050 : 13'h040, 0, 0);
    @(negedge clk);
    chk("tie_idle", {30'd0, m1_gnt, m0_gnt}, 32'd0);
    tick();
    @(negedge clk);
    chk("tie_first", {30'd0, m1_gnt, m0_gnt}, first ? 32'd2 : 32'd1);
    tick();
    drive(first, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("tie_handover", {30'd0, m1_gnt, m0_gnt}, sec ? 32'd2 : 32'd1);
    tick();
    drive(sec, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("tie_done", {30'd0, m1_gnt, m0_gnt}, 32'd0);
  endtask

  // Monitor: every bus access and every ack is matched against the queues.
  always @(negedge clk) begin
    chk("gnt_exclusive", {31'd0, m0_gnt & m1_gnt}, 32'd0);
    if (bus_sel === 1'b1) begin
      if (bus_q.size() == 0) begin
        total++; bad++;
        $display("FAIL bus_unexpected: got addr %h expected no access", bus_addr);
      end else begin
        bus_t b;
        b = bus_q.pop_front();
        chk("bus_owner", {31'd0, m1_gnt}, {31'd0, b.m});
        chk("bus_addr",  {19'd0, bus_addr}, {19'd0, b.addr});
        chk("bus_we",    {31'd0, bus_we}, {31'd0, b.we});
        chk("bus_wdata", bus_wdata, b.wd);
      end
    end
    for (int k = 0; k < 2; k++) begin
      if ((k == 0 ? m0_ack : m1_ack) === 1'b1) begin
        if (ack_q.size() == 0) begin
          total++; bad++;
          $display("FAIL ack_unexpected: got ack on m%0d expected none", k);
        end else begin
          ack_t e;
          e = ack_q.pop_front();
          chk("ack_master", k, {31'd0, e.m});
          chk("ack_rdata", k == 0 ? m0_rdata : m1_rdata, e.rd);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, nsel;
    bit got1, prev0, adj;

    // Reset state and single read.
    reset_dut();
    solo(0, 13'h010, 0, 0);
    chk("single_rdata", m0_rdata, 32'hDEADBEEF);

    // Ties after reset: m0 first; after a lone m0 access a tie goes to m1.
    reset_dut();
    tie(0);
    solo(0, 13'h011, 0, 0);
    tie(1);

    // Locked burst of 4 writes, m1 idle.
    tick();
    drive(0, 1, 1, 13'h100, 1, 32'd1);
    for (int i = 0; i < 4; i++) push(0, 13'h100 + 13'(i), 1, 32'(i + 1));
    @(negedge clk);
    tick();
    nsel = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus_sel) nsel++;
      chk("burst_m1_gnt", {31'd0, m1_gnt}, 32'd0);
      tick();
      if (i < 3) drive(0, 1, (i + 1) < 3, 13'h100 + 13'(i + 1), 1, 32'(i + 2));
      else       drive(0, 0, 0, 0, 0, 0);
    end
    @(negedge clk);
    chk("burst_sel_cycles", nsel, 32'd4);
    chk("burst_end_sel", {31'd0, bus_sel}, 32'd0);

    // Starvation limit: m0 locked reads while m1 waits.
    tick();
    drive(0, 1, 1, 13'h020, 0, 0);
    for (int i = 0; i < 4; i++) push(0, 13'h020, 0, 0);
    push(1, 13'h030, 0, 0);
    @(negedge clk);
    tick();
    drive(1, 1, 0, 13'h030, 0, 0);
    n0 = 0; got1 = 0; prev0 = 0; adj = 0;
    for (int i = 0; i < 12 && !got1; i++) begin
      @(negedge clk);
      if (m1_gnt) begin
        got1 = 1; adj = prev0;
        m0_req = 0;
      end else begin
        prev0 = m0_gnt && bus_sel;
        if (prev0) n0++;
        tick();
      end
    end
    chk("starve_m1_granted", {31'd0, got1}, 32'd1);
    chk("starve_m0_count", n0, 32'd4);
    chk("starve_handover_adjacent", {31'd0, adj}, 32'd1);
    tick();
    drive(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    tick();

    // Write integrity on m1; rdata keeps the earlier read value.
    solo(1, 13'h0AB, 1, 32'h12345678);
    tick();
    @(negedge clk);
    chk("write_rdata_kept", m1_rdata, slave(13'h030));

    // Reset during an OWN1 access cycle.
    tick();
    drive(1, 1, 0, 13'h060, 0, 0);
    bus_q.push_back('{m: 1'b1, addr: 13'h060, we: 1'b0, wd: '0});
    @(negedge clk);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_owned", {31'd0, m1_gnt}, 32'd1);
    tick();
    rst = 1'b0;
    drive(1, 0, 0, 0, 0, 0);
    exp_rd[0] = '0; exp_rd[1] = '0;
    @(negedge clk);
    check_idle("rstmid");

    repeat (3) tick();
    chk("bus_q_drained", bus_q.size(), 32'd0);
    chk("ack_q_drained", ack_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
